// File: rtl/ptos_lane_sched_if.sv
// rtl/ptos_lane_sched_if.sv - upstream byte handshake between producer and lane scheduler
//
// Purpose : groups the byte-wide valid/ready upstream channel.
// Signals : in_data  - upstream byte
//           in_valid - byte available (sampled only on boundary cycles)
//           in_ready - scheduler takes the byte this cycle
// Modports: master = upstream producer, slave = ptos_lane_sched
interface ptos_lane_sched_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ptos_lane_sched.sv
// rtl/ptos_lane_sched.sv - transmit lane scheduler: training, idle fill, MSB-first serializer
//
// Purpose : after enable, sends TRAIN_LEN COM symbols, then IDLE fill or upstream
//           payload bytes, one bit per clk, MSB first.
// Ports   : clk        - single bit-rate clock
//           reset      - synchronous, active-high
//           enable     - lane enable (acts at byte boundaries and in OFF)
//           up         - upstream byte handshake (slave side)
//           out_serial - serial lane bit
//           out_byte   - byte currently being shifted
//           byte_load  - pulse on the first bit of each new byte
//           is_data    - current byte is payload
//           active     - link trained
//           state      - 0=OFF 1=TRAIN 2=IDLE 3=DATA
module ptos_lane_sched #(
  parameter int         TRAIN_LEN = 4,
  parameter logic [7:0] COM_SYM   = 8'hBC,
  parameter logic [7:0] IDL_SYM   = 8'h7C
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  ptos_lane_sched_if.slave         up,
  output logic                     out_serial,
  output logic [7:0]               out_byte,
  output logic                     byte_load,
  output logic                     is_data,
  output logic                     active,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_IDLE  = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  localparam logic [3:0] TRAIN_LAST = 4'(TRAIN_LEN - 1);

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_train_cnt;
  logic [7:0] r_out_byte;
  logic       r_byte_load;
  logic       r_is_data;
  logic       r_active;

  logic w_boundary;
  logic w_train_done;
  logic w_in_ready;

  assign w_boundary   = (r_state != ST_OFF) && (r_bit_cnt == 3'd7);
  // The final TRAIN boundary already picks between IDLE and DATA, so it can accept a byte.
  assign w_train_done = (r_state != ST_TRAIN) || (r_train_cnt == TRAIN_LAST);
  assign w_in_ready   = w_boundary && enable && w_train_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_OFF;
      r_bit_cnt   <= 3'd0;
      r_train_cnt <= 4'd0;
      r_out_byte  <= 8'd0;
      r_byte_load <= 1'b0;
      r_is_data   <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_byte_load <= 1'b0;
      if (r_state == ST_OFF) begin
        r_bit_cnt <= 3'd0;
        if (enable) begin
          r_state     <= ST_TRAIN;
          r_train_cnt <= 4'd0;
          r_out_byte  <= COM_SYM;
          r_byte_load <= 1'b1;
          r_is_data   <= 1'b0;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + 3'd1;  // wraps 7->0 exactly at the reload edge
        if (w_boundary) begin
          if (!enable) begin
            r_state     <= ST_OFF;
            r_train_cnt <= 4'd0;
            r_out_byte  <= 8'd0;
            r_is_data   <= 1'b0;
            r_active    <= 1'b0;
          end else if (!w_train_done) begin
            r_out_byte  <= COM_SYM;
            r_train_cnt <= r_train_cnt + 4'd1;
            r_byte_load <= 1'b1;
          end else begin
            r_active    <= 1'b1;
            r_byte_load <= 1'b1;
            if (up.in_valid) begin
              r_state    <= ST_DATA;
              r_out_byte <= up.in_data;
              r_is_data  <= 1'b1;
            end else begin
              r_state    <= ST_IDLE;
              r_out_byte <= IDL_SYM;
              r_is_data  <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign up.in_ready = w_in_ready;
  assign out_serial  = (r_state != ST_OFF) ? r_out_byte[3'd7 - r_bit_cnt] : 1'b0;
  assign out_byte    = r_out_byte;
  assign byte_load   = r_byte_load;
  assign is_data     = r_is_data;
  assign active      = r_active;
  assign state       = r_state;

endmodule
